// File: rtl/spi32_target.sv
// SPI mode 0 target: oversamples SCLK/CS_N/SDI in the clk domain, receives MSB-first
// 32-bit words on SDI and shifts a preloaded 32-bit response word out on SDO.
module spi32_target #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk_in,
    input  logic        cs_n_in,
    input  logic        sdi,
    output logic        sdo,
    input  logic [31:0] tx_din,
    input  logic        tx_load,
    output logic        tx_ready,
    output logic [31:0] rx_dout,
    output logic        rx_valid,
    output logic        busy,
    output logic        underrun,
    output logic        frame_err
);

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_meta, cs_meta, sdi_meta;
    logic sclk_s, sclk_d, cs_s, cs_d, sdi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [31:0] rx_shift, tx_shift, hold;
    logic        hold_full;
    logic [4:0]  bit_cnt;
    logic        wrapped;

    logic start_frame, end_frame, do_sample, do_shift, do_reload;
    logic reload_evt, consume, load_accept;

    // CS chain resets high so the idle-high pin never looks like a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_meta <= '0;
            cs_meta   <= '1;
            sdi_meta  <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_meta <= {sclk_meta[SYNC_STAGES-2:0], sclk_in};
            cs_meta   <= {cs_meta[SYNC_STAGES-2:0], cs_n_in};
            sdi_meta  <= {sdi_meta[SYNC_STAGES-2:0], sdi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_meta[SYNC_STAGES-1];
    assign cs_s      = cs_meta[SYNC_STAGES-1];
    assign sdi_s     = sdi_meta[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // CS rising takes priority over any SCLK edge seen in the same cycle.
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        do_sample   = 1'b0;
        do_shift    = 1'b0;
        do_reload   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt   = SHIFT;
                    start_frame = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    end_frame = 1'b1;
                end else begin
                    do_sample = sclk_rise;
                    if (sclk_fall) begin
                        if (bit_cnt != 5'd0) do_shift  = 1'b1;
                        else if (wrapped)    do_reload = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Holding register handshake: a word is accepted when tx_load is high and
    // tx_ready is high, or when the same cycle's reload empties the register.
    assign reload_evt  = start_frame | do_reload;
    assign consume     = reload_evt & hold_full;
    assign load_accept = tx_load & (~hold_full | consume);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_shift  <= '0;
            tx_shift  <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            wrapped   <= 1'b0;
            rx_dout   <= '0;
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;

            if (load_accept) hold <= tx_din;
            if (load_accept)  hold_full <= 1'b1;
            else if (consume) hold_full <= 1'b0;

            if (reload_evt) begin
                tx_shift <= hold_full ? hold : 32'd0;
                underrun <= ~hold_full;
            end else if (do_shift) begin
                tx_shift <= {tx_shift[30:0], 1'b0};
            end

            if (start_frame) begin
                bit_cnt  <= '0;
                wrapped  <= 1'b0;
                rx_shift <= '0;
            end

            if (do_sample) begin
                rx_shift <= {rx_shift[30:0], sdi_s};
                bit_cnt  <= bit_cnt + 5'd1;
                if (bit_cnt == 5'd31) begin
                    rx_dout  <= {rx_shift[30:0], sdi_s};
                    rx_valid <= 1'b1;
                    wrapped  <= 1'b1;
                end
            end

            if (end_frame) begin
                frame_err <= (bit_cnt != 5'd0);
                bit_cnt   <= '0;
            end
        end
    end

    // busy mirrors the FSM state directly.
    assign busy     = (state == SHIFT);
    assign sdo      = (state == SHIFT) & tx_shift[31];
    assign tx_ready = ~hold_full;

endmodule

// File: tb/tb_spi32_target.sv
// Directed bench for spi32_target: a bit-banged mode 0 master at 4 clk per half-bit,
// with a pulse monitor and an expected queue of received words.
module tb_spi32_target;

    logic        clk = 1'b0;
    logic        reset, sclk_in, cs_n_in, sdi, sdo;
    logic [31:0] tx_din, rx_dout;
    logic        tx_load, tx_ready, rx_valid, busy, underrun, frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int rx_cnt  = 0;
    int un_cnt  = 0;
    int fe_cnt  = 0;
    int rx0, un0, fe0;
    logic [31:0] exp_q[$];
    logic [31:0] m1, m2;

    spi32_target #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sclk_in(sclk_in), .cs_n_in(cs_n_in), .sdi(sdi),
        .sdo(sdo), .tx_din(tx_din), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_dout(rx_dout), .rx_valid(rx_valid), .busy(busy), .underrun(underrun),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse monitor and receive scoreboard.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_cnt++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL rx_unexpected: observed %h expected no word", rx_dout);
            end else begin
                chk("rx_word", rx_dout, exp_q.pop_front());
            end
        end
        if (underrun === 1'b1)  un_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [31:0] v);
        tx_din  = v;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    task automatic cs_low();
        cs_n_in = 1'b0;
        tick(8);
    endtask

    // Master drives SDI, samples SDO just before each rise; on the last bit of a
    // frame SCLK falls and CS rises together.
    task automatic xfer(input logic [31:0] mosi, input int nbits, input bit last,
                        input bit mid_load, input logic [31:0] mid_val,
                        output logic [31:0] miso);
        miso = '0;
        for (int i = 0; i < nbits; i++) begin
            sdi = mosi[31-i];
            if (mid_load && i == 15) begin
                load(mid_val);
                tick(3);
            end else begin
                tick(4);
            end
            miso    = {miso[30:0], sdo};
            sclk_in = 1'b1;
            tick(4);
            sclk_in = 1'b0;
            if (last && i == nbits - 1) cs_n_in = 1'b1;
        end
        if (last) begin
            sdi = 1'b0;
            tick(10);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_sdo", 32'(sdo), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_rx_dout", rx_dout, 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sclk_in = 1'b0; cs_n_in = 1'b1; sdi = 1'b0;
        tx_din = '0; tx_load = 1'b0;
        tick(3);
        chk_reset_vals();
        reset = 1'b0;
        tick(3);

        // Single word, nothing loaded.
        exp_q.push_back(32'hDEADBEEF);
        cs_low();
        chk("t1_busy", 32'(busy), 32'd1);
        xfer(32'hDEADBEEF, 32, 1'b1, 1'b0, 32'd0, m1);
        chk("t1_rx_cnt", 32'(rx_cnt), 32'd1);
        chk("t1_rx_dout", rx_dout, 32'hDEADBEEF);
        chk("t1_frame_err", 32'(fe_cnt), 32'd0);
        chk("t1_underrun", 32'(un_cnt), 32'd1);
        chk("t1_miso", m1, 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // Preloaded response.
        un0 = un_cnt;
        load(32'hA5A50F0F);
        chk("t2_tx_ready_lo", 32'(tx_ready), 32'd0);
        exp_q.push_back(32'h00000000);
        cs_low();
        chk("t2_tx_ready_hi", 32'(tx_ready), 32'd1);
        xfer(32'h00000000, 32, 1'b1, 1'b0, 32'd0, m1);
        chk("t2_miso", m1, 32'hA5A50F0F);
        chk("t2_underrun", 32'(un_cnt - un0), 32'd0);
        chk("t2_rx_cnt", 32'(rx_cnt), 32'd2);
        chk("t2_rx_dout", rx_dout, 32'h00000000);

        // Two words in one frame, second response loaded during word one.
        un0 = un_cnt;
        load(32'h11111111);
        exp_q.push_back(32'h01234567);
        exp_q.push_back(32'h89ABCDEF);
        cs_low();
        xfer(32'h01234567, 32, 1'b0, 1'b1, 32'h22222222, m1);
        xfer(32'h89ABCDEF, 32, 1'b1, 1'b0, 32'd0, m2);
        chk("t3_miso1", m1, 32'h11111111);
        chk("t3_miso2", m2, 32'h22222222);
        chk("t3_underrun", 32'(un_cnt - un0), 32'd0);
        chk("t3_rx_cnt", 32'(rx_cnt), 32'd4);
        chk("t3_rx_dout", rx_dout, 32'h89ABCDEF);
        chk("t3_tx_ready", 32'(tx_ready), 32'd1);

        // Partial word then a full frame.
        rx0 = rx_cnt; fe0 = fe_cnt;
        cs_low();
        xfer(32'hABCDE123, 12, 1'b1, 1'b0, 32'd0, m1);
        chk("t4_frame_err", 32'(fe_cnt - fe0), 32'd1);
        chk("t4_no_rx", 32'(rx_cnt - rx0), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_rx_dout_kept", rx_dout, 32'h89ABCDEF);
        exp_q.push_back(32'h0000FFFF);
        cs_low();
        xfer(32'h0000FFFF, 32, 1'b1, 1'b0, 32'd0, m1);
        chk("t4_rx_dout", rx_dout, 32'h0000FFFF);
        chk("t4_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
        chk("t4_fe_once", 32'(fe_cnt - fe0), 32'd1);

        // Reset in the middle of a frame.
        rx0 = rx_cnt; fe0 = fe_cnt;
        cs_low();
        xfer(32'hCAFEF00D, 20, 1'b0, 1'b0, 32'd0, m1);
        reset = 1'b1; cs_n_in = 1'b1; sclk_in = 1'b0; sdi = 1'b0;
        #1;
        chk_reset_vals();
        tick(3);
        reset = 1'b0;
        tick(5);
        chk("t5_no_rx", 32'(rx_cnt - rx0), 32'd0);
        chk("t5_no_fe", 32'(fe_cnt - fe0), 32'd0);
        exp_q.push_back(32'h12345678);
        cs_low();
        xfer(32'h12345678, 32, 1'b1, 1'b0, 32'd0, m1);
        chk("t5_rx_dout", rx_dout, 32'h12345678);
        chk("t5_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
        chk("t5_fe", 32'(fe_cnt - fe0), 32'd0);

        // Load while full is ignored.
        load(32'h5555AAAA);
        chk("t6_tx_ready_1", 32'(tx_ready), 32'd0);
        load(32'hBAD0BAD0);
        chk("t6_tx_ready_2", 32'(tx_ready), 32'd0);
        exp_q.push_back(32'h0F0F0F0F);
        cs_low();
        xfer(32'h0F0F0F0F, 32, 1'b1, 1'b0, 32'd0, m1);
        chk("t6_miso", m1, 32'h5555AAAA);
        chk("t6_rx_dout", rx_dout, 32'h0F0F0F0F);
        chk("t6_tx_ready_end", 32'(tx_ready), 32'd1);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
